// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream source and the line-buffer window chain.
package pixel_stream_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned DEF_WIDTH  = 17;
  localparam int unsigned DEF_HEIGHT = 17;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_READ  = 2'd1,
    PS_FLUSH = 2'd2,
    PS_DRAIN = 2'd3
  } ps_state_e;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Output register plus one-entry skid register; reports how many of the two slots are free.
module pixel_skid_buffer
  import pixel_stream_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [PIX_W-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [PIX_W-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       slots_free_o
);

  logic             out_v_q, out_v_d;
  logic             skid_v_q, skid_v_d;
  logic [PIX_W-1:0] out_d_q, out_d_d;
  logic [PIX_W-1:0] skid_d_q, skid_d_d;
  logic             take;

  // Arriving data is presented in its arrival cycle when nothing is held, and
  // only latched if it is not accepted; the skid entry is always the younger one.
  always_comb begin
    out_valid_o = out_v_q | in_valid_i;
    out_data_o  = out_v_q ? out_d_q : (in_valid_i ? in_data_i : '0);
    take        = out_valid_o & out_ready_i;
    out_v_d     = out_v_q;
    out_d_d     = out_d_q;
    skid_v_d    = skid_v_q;
    skid_d_d    = skid_d_q;
    if (out_v_q) begin
      if (take) begin
        if (skid_v_q) begin
          out_d_d  = skid_d_q;
          skid_v_d = in_valid_i;
          if (in_valid_i) skid_d_d = in_data_i;
        end else begin
          out_v_d = in_valid_i;
          if (in_valid_i) out_d_d = in_data_i;
        end
      end else if (in_valid_i) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data_i;
      end
    end else if (in_valid_i && !out_ready_i) begin
      out_v_d = 1'b1;
      out_d_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_d_q  <= '0;
      skid_d_q <= '0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_d_q  <= out_d_d;
      skid_d_q <= skid_d_d;
    end
  end

  assign slots_free_o = 2'd2 - {1'b0, out_v_q} - {1'b0, skid_v_q};

endmodule

// File: rtl/pixel_stream_source.sv
// Reads a raster image from frame memory, streams it out, then appends flush rows.
module pixel_stream_source
  import pixel_stream_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter int unsigned      HEIGHT     = DEF_HEIGHT,
  parameter int unsigned      FLUSH_ROWS = 4,
  parameter logic [PIX_W-1:0] FLUSH_VAL  = 8'd0,
  parameter int unsigned      ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [PIX_W-1:0]  mem_data_i,
  output logic [PIX_W-1:0]  data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(HEIGHT + FLUSH_ROWS + 1);
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] IMG_ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0] ALL_ROW_LAST = ROW_W'(HEIGHT + FLUSH_ROWS - 1);

  ps_state_e         state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, col_next;
  logic [ROW_W-1:0]  row_q, row_d, row_next;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic              pend_flush_q, pend_flush_d;
  logic [1:0]        slots_free;
  logic [2:0]        room;
  logic              issue_ok, col_wrap, buf_empty;
  logic [PIX_W-1:0]  in_data;

  pixel_skid_buffer u_skid (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (pend_q),
    .in_data_i    (in_data),
    .out_valid_o  (valid_o),
    .out_data_o   (data_o),
    .out_ready_i  (ready_i),
    .slots_free_o (slots_free)
  );

  assign in_data = pend_flush_q ? FLUSH_VAL : mem_data_i;

  // A beat issued now lands next cycle; the worst case assumes no transfer then.
  always_comb begin
    room      = {1'b0, slots_free} + {2'b0, valid_o & ready_i} - {2'b0, pend_q};
    issue_ok  = (room != 3'd0);
    col_wrap  = (col_q == COL_LAST);
    col_next  = col_wrap ? '0 : col_q + 1'b1;
    row_next  = col_wrap ? row_q + 1'b1 : row_q;
    buf_empty = (slots_free == 2'd2) && !pend_q;
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    pend_d       = 1'b0;
    pend_flush_d = 1'b0;
    mem_rd_o     = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      PS_IDLE: begin
        if (start_i) begin
          state_d = PS_READ;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      PS_READ: begin
        if (issue_ok) begin
          mem_rd_o = 1'b1;
          pend_d   = 1'b1;
          addr_d   = addr_q + 1'b1;
          col_d    = col_next;
          row_d    = row_next;
          if (col_wrap && row_q == IMG_ROW_LAST)
            state_d = (FLUSH_ROWS == 0) ? PS_DRAIN : PS_FLUSH;
        end
      end
      PS_FLUSH: begin
        if (issue_ok) begin
          pend_d       = 1'b1;
          pend_flush_d = 1'b1;
          col_d        = col_next;
          row_d        = row_next;
          if (col_wrap && row_q == ALL_ROW_LAST) state_d = PS_DRAIN;
        end
      end
      PS_DRAIN: begin
        if (buf_empty) begin
          done_o  = 1'b1;
          state_d = PS_IDLE;
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PS_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != PS_IDLE) && !done_o;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench: three configurations (flush 0s, no flush, flush 8'hFF) driven one at a time.
module tb_pixel_stream_source;

  logic clk = 1'b0;
  logic rst, ready;
  logic [2:0]       start_v, rd_v, vld_v, busy_v, done_v;
  logic [2:0][9:0]  addr_v;
  logic [2:0][7:0]  dout_v;

  int cyc = 0;
  int checks = 0, fails = 0;
  int sel = 0;
  int beat_cnt = 0, done_cnt = 0, last_beat_cyc = 0, done_cyc = 0;
  int b0, done_base, t0;
  logic [7:0]  exp_q[$];
  logic [7:0]  e, prev_data;
  logic        prev_stall = 1'b0, prev_done = 1'b0;
  logic [15:0] pat = 16'b1100_0110_1011_1001;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned H = (g == 1) ? 2 : 3;
    localparam int unsigned F = (g == 1) ? 0 : 2;
    localparam logic [7:0]  V = (g == 2) ? 8'hFF : 8'h00;
    logic [7:0] mdat;
    always @(posedge clk) if (rd_v[g]) mdat <= 8'(addr_v[g] + 10'd1);
    pixel_stream_source #(.WIDTH(4), .HEIGHT(H), .FLUSH_ROWS(F), .FLUSH_VAL(V), .ADDR_W(10)) u_dut (
      .clk(clk), .rst(rst), .start_i(start_v[g]), .mem_rd_o(rd_v[g]), .mem_addr_o(addr_v[g]),
      .mem_data_i(mdat), .data_o(dout_v[g]), .valid_o(vld_v[g]), .ready_i(ready),
      .busy_o(busy_v[g]), .done_o(done_v[g]));
  end

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on every transfer of the active instance.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      chk("idle_dut_valid", int'(vld_v & ~(3'(1) << sel)), 0);
      if (prev_stall) begin
        chk("hold_valid", int'(vld_v[sel]), 1);
        chk("hold_data", int'(dout_v[sel]), int'(prev_data));
      end
      if (vld_v[sel] && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: got %0d expected no beat (cycle %0d)", dout_v[sel], cyc);
        end else begin
          e = exp_q.pop_front();
          if (dout_v[sel] != e) begin
            fails++;
            $display("FAIL beat_data: got %0d expected %0d (cycle %0d)", dout_v[sel], e, cyc);
          end
        end
        beat_cnt++;
        last_beat_cyc = cyc;
      end
      prev_stall = vld_v[sel] & ~ready;
      prev_data  = dout_v[sel];
      if (prev_done) chk("done_width", int'(done_v[sel]), 0);
      if (done_v[sel]) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", int'(busy_v[sel]), 0);
      end
      prev_done = done_v[sel];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int d);
    int h = (d == 1) ? 2 : 3;
    int f = (d == 1) ? 0 : 2;
    logic [7:0] v = (d == 2) ? 8'hFF : 8'h00;
    for (int i = 0; i < 4 * h; i++) exp_q.push_back(8'(i + 1));
    for (int i = 0; i < 4 * f; i++) exp_q.push_back(v);
  endtask

  task automatic check_idle(input int d);
    chk("idle_rd", int'(rd_v[d]), 0);
    chk("idle_addr", int'(addr_v[d]), 0);
    chk("idle_data", int'(dout_v[d]), 0);
    chk("idle_valid", int'(vld_v[d]), 0);
    chk("idle_busy", int'(busy_v[d]), 0);
    chk("idle_done", int'(done_v[d]), 0);
  endtask

  // Called at cycle t; returns at t+2 after checking the first read and first beat.
  task automatic start_frame(input int d);
    b0 = beat_cnt;
    done_base = done_cnt;
    t0 = cyc;
    push_frame(d);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    chk("start_busy", int'(busy_v[d]), 1);
    chk("start_rd", int'(rd_v[d]), 1);
    chk("start_addr", int'(addr_v[d]), 0);
    tick();
    chk("first_valid", int'(vld_v[d]), 1);
    chk("first_data", int'(dout_v[d]), 1);
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      if (toggle) ready = pat[cyc[3:0]];
      tick();
      n++;
    end
    ready = 1'b1;
    chk("done_seen", done_cnt - done_base, 1);
    tick();
    tick();
  endtask

  task automatic end_frame(input int nbeats);
    chk("beat_count", beat_cnt - b0, nbeats);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; start_v = '0;
    repeat (2) tick();
    for (int d = 0; d < 3; d++) check_idle(d);
    rst = 1'b0;
    tick();

    // basic frame
    sel = 0;
    start_frame(0);
    wait_done(100, 1'b0);
    chk("t1_last_beat", last_beat_cyc - t0, 21);
    chk("t1_done", done_cyc - t0, 22);
    end_frame(20);

    // backpressure
    start_frame(0);
    wait_done(400, 1'b1);
    end_frame(20);

    // no flush
    sel = 1;
    start_frame(1);
    wait_done(100, 1'b0);
    chk("t3_last_beat", last_beat_cyc - t0, 9);
    chk("t3_done", done_cyc - t0, 10);
    end_frame(8);

    // starts while busy and coincident with done are ignored
    sel = 0;
    start_frame(0);
    while (cyc < t0 + 23) begin
      start_v[0] = (cyc == t0 + 6) || (cyc == t0 + 13) || (cyc == t0 + 22);
      tick();
    end
    start_v[0] = 1'b0;
    chk("t4_done", done_cyc - t0, 22);
    repeat (8) tick();
    chk("t4_single_done", done_cnt - done_base, 1);
    chk("t4_idle_busy", int'(busy_v[0]), 0);
    end_frame(20);
    start_frame(0);
    wait_done(100, 1'b0);
    end_frame(20);

    // reset mid-frame
    start_frame(0);
    for (int n = 0; n < 50 && beat_cnt - b0 < 5; n++) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    check_idle(0);
    rst = 1'b0;
    repeat (5) tick();
    chk("t5_no_done", done_cnt - done_base, 0);
    start_frame(0);
    wait_done(100, 1'b0);
    end_frame(20);

    // ready low across the image/flush boundary, flush value 8'hFF
    sel = 2;
    start_frame(2);
    while (cyc < t0 + 12) tick();
    ready = 1'b0;
    repeat (6) tick();
    ready = 1'b1;
    wait_done(100, 1'b0);
    chk("t6_last_beat", last_beat_cyc - t0, 27);
    chk("t6_done", done_cyc - t0, 28);
    end_frame(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
